// File: rtl/uart_cmd_decoder_pkg.sv
// Purpose: shared constants, state encoding and error codes for the UART command decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_REG   = 8'h01;
  localparam logic [7:0] CMD_MEM   = 8'h02;

  localparam logic [1:0] ERR_CMD = 2'd0;
  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_OVF = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  // DONE_WAIT holds a good MEM frame until its last write has been accepted.
  typedef enum logic [3:0] {
    ST_HUNT,
    ST_CMD,
    ST_REG_A,
    ST_REG_D,
    ST_ADR_H,
    ST_ADR_L,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE_WAIT
  } state_t;

endpackage

// File: rtl/uart_cmd_decoder_timer.sv
// Purpose: inter-byte watchdog; counts clocks since the last load and flags expiry.
// Latency: expired rises TIMEOUT_CLKS cycles after the last load and stays up until reloaded.
// Backpressure: none; load always wins.
module uart_cmd_timer #(
  parameter int unsigned TIMEOUT_CLKS = 20880
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CLKS);

  logic [CW-1:0] cnt;

  // Saturating up-counter, cleared by load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Purpose: parse A5-framed host commands from the UART byte stream into VIC register writes and memory byte writes.
// Latency: every output is registered one cycle after the rx byte that causes it; MEM done waits for the last write to be accepted.
// Backpressure: mem_valid holds until mem_ready; a payload byte arriving while a write is still pending aborts the frame (overflow).
// Optional feature: define UART_CMD_TIMEOUT_EN to abort stalled frames after TIMEOUT_CLKS idle cycles.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int          ADDR_W       = 14,
  parameter int unsigned TIMEOUT_CLKS = 20880
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              reg_we,
  output logic [5:0]        reg_addr,
  output logic [7:0]        reg_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t            state;
  logic [7:0]        chk;
  logic [8:0]        byte_cnt;
  logic [8:0]        len;
  logic [ADDR_W-9:0] addr_hi;
  logic              is_mem;
  logic              tmo;

`ifdef UART_CMD_TIMEOUT_EN
  // Idle time is measured from the latest byte; sitting in HUNT keeps it cleared.
  uart_cmd_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (rx_valid || (state == ST_HUNT)),
    .expired (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  // Frame parser: one state step per received byte, with write handshake and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HUNT;
      chk       <= '0;
      byte_cnt  <= '0;
      len       <= '0;
      addr_hi   <= '0;
      is_mem    <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_data  <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      reg_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;

      // Retire an accepted write; a payload byte below may immediately queue the next one.
      if (mem_valid && mem_ready) begin
        mem_valid <= 1'b0;
        mem_addr  <= mem_addr + 1'b1;
      end

      if (state == ST_DONE_WAIT) begin
        if (!mem_valid || mem_ready) begin
          done  <= 1'b1;
          state <= ST_HUNT;
        end else if (tmo) begin
          err      <= 1'b1;
          err_code <= ERR_TMO;
          state    <= ST_HUNT;
        end
      end else if (rx_valid) begin
        if (state != ST_HUNT && state != ST_CHECK) begin
          chk <= chk ^ rx_data;
        end
        case (state)
          ST_HUNT: begin
            if (rx_data == SYNC_BYTE) begin
              chk   <= '0;
              state <= ST_CMD;
            end
          end
          ST_CMD: begin
            if (rx_data == CMD_REG) begin
              is_mem <= 1'b0;
              state  <= ST_REG_A;
            end else if (rx_data == CMD_MEM) begin
              is_mem <= 1'b1;
              state  <= ST_ADR_H;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_CMD;
              state    <= ST_HUNT;
            end
          end
          ST_REG_A: begin
            reg_addr <= rx_data[5:0];
            state    <= ST_REG_D;
          end
          ST_REG_D: begin
            reg_data <= rx_data;
            state    <= ST_CHECK;
          end
          ST_ADR_H: begin
            addr_hi <= rx_data[ADDR_W-9:0];
            state   <= ST_ADR_L;
          end
          ST_ADR_L: begin
            mem_addr <= {addr_hi, rx_data};
            state    <= ST_LEN;
          end
          ST_LEN: begin
            len      <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            byte_cnt <= '0;
            state    <= ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            if (mem_valid && !mem_ready) begin
              err      <= 1'b1;
              err_code <= ERR_OVF;
              state    <= ST_HUNT;
            end else begin
              mem_valid <= 1'b1;
              mem_data  <= rx_data;
              byte_cnt  <= byte_cnt + 9'd1;
              if (byte_cnt + 9'd1 == len) begin
                state <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            if (rx_data != chk) begin
              err      <= 1'b1;
              err_code <= ERR_CHK;
              state    <= ST_HUNT;
            end else if (!is_mem) begin
              reg_we <= 1'b1;
              done   <= 1'b1;
              state  <= ST_HUNT;
            end else if (!mem_valid || mem_ready) begin
              done  <= 1'b1;
              state <= ST_HUNT;
            end else begin
              state <= ST_DONE_WAIT;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end else if (tmo && state != ST_HUNT) begin
        err      <= 1'b1;
        err_code <= ERR_TMO;
        state    <= ST_HUNT;
      end
    end
  end

endmodule
